alu_decoder_pipe: RTL
=====================

// Module: alu_decoder_pipe
// PURPOSE
//  Parametrised RV32I ALU-control decoder; successor to the single-register ALU decoder.
//  Decodes alu_op/funct3/funct7/op_5 into an ALU opcode and an illegal flag.
//  Decode runs through a PIPE_STAGES-deep valid/ready pipeline and keeps a saturating count of illegal decodes.
//  Sits between the main control decoder and the ALU / mul-div unit in the execute path.
// PARAMETERS
//  CTRL_W        5  alu_control width; >=4, or >=5 when ALU_DEC_MULDIV_EN is defined
//  PIPE_STAGES   1  register stages between input and output handshake, legal values 1 or 2
//  ILL_CNT_W     8  width of the saturating illegal-decode counter
// PORTS
//  clk            in   1          clock, rising edge
//  rst_n          in   1          asynchronous active-low reset
//  in_valid       in   1          decode request valid
//  in_ready       out  1          pipeline can accept a request this cycle
//  alu_op         in   2          00 add, 01 sub, 10 decode funct, 11 reserved
//  funct3         in   3          instr[14:12]
//  funct7         in   7          instr[31:25]
//  op_5           in   1          instr[5]; 1 = R-type, 0 = I-type
//  out_valid      out  1          alu_control/illegal are valid
//  out_ready      in   1          consumer accepts the output
//  alu_control    out  CTRL_W     ALU opcode; see encoding below
//  illegal        out  1          the encoding is not a legal ALU op
//  ill_cnt        out  ILL_CNT_W  count of illegal outputs accepted, saturating
//  ill_cnt_clr    in   1          synchronous clear of ill_cnt
// BEHAVIOUR
//  Encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
//    M-extension: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
//  alu_op 00 -> ADD; alu_op 01 -> SUB; alu_op 11 -> ADD with illegal=1.
//  alu_op 10, op_5=1 (R-type):
//    funct7 0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
//    funct7 0100000: f3 000 SUB, f3 101 SRA; any other f3 -> illegal.
//    funct7 0000001 -> M op (see CONFIGURATION). Any other funct7 -> illegal.
//  alu_op 10, op_5=0 (I-type):
//    funct7 ignored except for shifts. f3 000 is always ADD (no SUBI).
//    f3 001 requires funct7=0 for SLL. f3 101 accepts 0 (SRL) or 0100000 (SRA).
//    Other funct7 values on f3 001/101 -> illegal.
//  Whenever illegal=1, alu_control=ADD (0).
//  Handshake:
//    A transfer occurs when valid & ready on the same edge. Latency from input to output is PIPE_STAGES cycles.
//    Full throughput: one request per cycle when out_ready is held high.
//    Each stage loads when it is empty or its downstream stage is advancing, so bubbles collapse.
//    in_ready = !stage0_valid | stage0_advance, combinational from out_ready.
//    Outputs hold stable while out_valid & !out_ready.
//  ill_cnt:
//    Increments on each output transfer with illegal=1 and saturates at all-ones.
//    ill_cnt_clr wins over a simultaneous increment; the counter reads 0 next cycle.
//  Reset (async assert, sync deassert is external):
//    All valid bits 0, alu_control 0, illegal 0, ill_cnt 0.
//    In-flight requests are dropped.
// CONFIGURATION
//  ALU_DEC_MULDIV_EN defined:
//    R-type funct7=0000001 decodes f3 000..111 to MUL..REMU (codes 16..23).
//    Elaboration error if CTRL_W < 5.
//  ALU_DEC_MULDIV_EN undefined:
//    funct7=0000001 -> illegal; codes 16..23 are never produced.
// STRUCTURE
//  Shared package alu_pkg:
//    localparams for the ALU opcode encodings
//    alu_op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
//    F7_BASE, F7_ALT, F7_MULDIV constants
//  Sub-module alu_dec_stage: one valid/ready register slice (data width CTRL_W+1).
//    Instantiated PIPE_STAGES times via generate.
//  Combinational decode function sits in front of stage 0.
// TESTING
//  1 R-type sweep: alu_op=10, op_5=1, funct7=0, f3 000..111 -> 0,7,5,6,4,8,3,2, illegal=0, 1 cycle later (PIPE_STAGES=1).
//  2 Alt/illegal: funct7=0100000 f3=000 -> 1; f3=101 -> 9; f3=110 -> 0 with illegal=1. I-type f3=000 funct7=0100000 -> 0, legal.
//  3 Backpressure: PIPE_STAGES=2, 4 back-to-back requests, out_ready low cycles 3-5.
//    Outputs held stable, no loss or duplication, order preserved, in_ready drops after 2 stalled entries.
//  4 Counter: 300 illegal transfers -> ill_cnt=255; ill_cnt_clr with a concurrent illegal transfer -> 0.
//  5 MULDIV: funct7=0000001, f3=100 -> 20 with macro defined; with macro undefined -> 0 with illegal=1.
//  6 Reset mid-flight: rst_n low with 2 entries in flight -> out_valid=0, ill_cnt=0 immediately.
//    First post-reset request appears after PIPE_STAGES cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the RV32I ALU-control decoder.
//   ALU opcode encodings (base and M-extension), alu_op codes from the main
//   control decoder, and the funct7 patterns the decoder distinguishes.
package alu_pkg;

    // ALU opcode encodings
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_AND  = 2;
    localparam int unsigned ALU_OR   = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_SLT  = 5;
    localparam int unsigned ALU_SLTU = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;
    // M-extension ops occupy ALU_MUL + funct3 (MUL..REMU = 16..23)
    localparam int unsigned ALU_MUL  = 16;

    // alu_op codes from the main control decoder (2'b11 is reserved)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // funct7 patterns
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_dec_stage.sv
// alu_dec_stage: one valid/ready register slice.
//   Loads whenever it is empty or its content is leaving this cycle, so
//   bubbles collapse and a full pipeline streams one item per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data [W-1:0]       upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data [W-1:0]      registered payload, held while stalled
module alu_dec_stage #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Ready is combinational from out_ready so a full slice can still accept.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_decoder_pipe.sv
// alu_decoder_pipe: RV32I ALU-control decoder behind a PIPE_STAGES-deep
//   valid/ready pipeline, with a saturating count of illegal decodes.
// Optional feature: define ALU_DEC_MULDIV_EN to decode the M-extension
//   (R-type funct7=0000001 -> codes 16..23; requires CTRL_W >= 5).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           request handshake
//   alu_op, funct3, funct7, op_5  decode inputs (op_5=1 R-type, 0 I-type)
//   out_valid/out_ready         result handshake
//   alu_control [CTRL_W-1:0]    ALU opcode (ADD when illegal)
//   illegal                     encoding is not a legal ALU op
//   ill_cnt [ILL_CNT_W-1:0]     illegal results accepted, saturating
//   ill_cnt_clr                 synchronous clear of ill_cnt (wins over increment)
module alu_decoder_pipe
    import alu_pkg::*;
#(
    parameter int unsigned CTRL_W      = 5,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned ILL_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           alu_op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 op_5,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    alu_control,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt,
    input  logic                 ill_cnt_clr
);

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("PIPE_STAGES must be 1 or 2");
    end
`ifdef ALU_DEC_MULDIV_EN
    if (CTRL_W < 5) begin : g_bad_width
        $error("CTRL_W must be >= 5 with ALU_DEC_MULDIV_EN");
    end
`else
    if (CTRL_W < 4) begin : g_bad_width
        $error("CTRL_W must be >= 4");
    end
`endif

    // Returns {illegal, alu_control}; an illegal decode always yields ADD.
    function automatic logic [CTRL_W:0] decode(input logic [1:0] op,
                                               input logic [2:0] f3,
                                               input logic [6:0] f7,
                                               input logic       r_type);
        logic        ill;
        int unsigned code;
        ill  = 1'b0;
        code = ALU_ADD;
        case (op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                if (r_type) begin
                    if (f7 == F7_BASE) begin
                        case (f3)
                            3'b000:  code = ALU_ADD;
                            3'b001:  code = ALU_SLL;
                            3'b010:  code = ALU_SLT;
                            3'b011:  code = ALU_SLTU;
                            3'b100:  code = ALU_XOR;
                            3'b101:  code = ALU_SRL;
                            3'b110:  code = ALU_OR;
                            default: code = ALU_AND;
                        endcase
                    end else if (f7 == F7_ALT) begin
                        if (f3 == 3'b000)      code = ALU_SUB;
                        else if (f3 == 3'b101) code = ALU_SRA;
                        else                   ill  = 1'b1;
                    end else if (f7 == F7_MULDIV) begin
`ifdef ALU_DEC_MULDIV_EN
                        code = ALU_MUL + {29'd0, f3};
`else
                        ill = 1'b1;
`endif
                    end else begin
                        ill = 1'b1;
                    end
                end else begin
                    // I-type: funct7 is immediate bits except on shifts.
                    case (f3)
                        3'b000: code = ALU_ADD;
                        3'b010: code = ALU_SLT;
                        3'b011: code = ALU_SLTU;
                        3'b100: code = ALU_XOR;
                        3'b110: code = ALU_OR;
                        3'b111: code = ALU_AND;
                        3'b001: begin
                            if (f7 == F7_BASE) code = ALU_SLL;
                            else               ill  = 1'b1;
                        end
                        default: begin
                            if (f7 == F7_BASE)     code = ALU_SRL;
                            else if (f7 == F7_ALT) code = ALU_SRA;
                            else                   ill  = 1'b1;
                        end
                    endcase
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) code = ALU_ADD;
        return {ill, CTRL_W'(code)};
    endfunction

    logic [CTRL_W:0] dec_data;
    logic [CTRL_W:0] out_data;

    assign dec_data = decode(alu_op, funct3, funct7, op_5);

    if (PIPE_STAGES == 1) begin : g_one
        alu_dec_stage #(.W(CTRL_W + 1)) u_s0 (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (dec_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );
    end else begin : g_two
        logic            mid_valid;
        logic            mid_ready;
        logic [CTRL_W:0] mid_data;

        alu_dec_stage #(.W(CTRL_W + 1)) u_s0 (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (dec_data),
            .out_valid (mid_valid),
            .out_ready (mid_ready),
            .out_data  (mid_data)
        );

        alu_dec_stage #(.W(CTRL_W + 1)) u_s1 (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (mid_valid),
            .in_ready  (mid_ready),
            .in_data   (mid_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );
    end

    assign {illegal, alu_control} = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (ill_cnt_clr) begin
            ill_cnt <= '0;
        end else if (out_valid && out_ready && illegal && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

endmodule
